dsp_mem_port_arbiter: RTL and testbench

Shares the core's single unified memory port between the instruction-fetch requester (IF) and the load/store requester (EX/MEM data path).
- Allows one outstanding transaction at a time.
- Data access has priority; a starvation counter guarantees forward progress for fetch.
- Routes each response back to its owner, and synthesises an error response if memory does not answer in time.

---
 rtl/dsp_mem_pkg.sv | 25 ++
 rtl/dsp_arb_starve_ctr.sv | 44 ++++
 rtl/dsp_mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dsp_mem_port_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mem_pkg.sv
// Shared definitions for the DSP core memory-port arbiter.
//   - default widths and parameter defaults
//   - arbiter FSM state encoding
//   - transaction owner encoding (fetch vs. data)
package dsp_mem_pkg;

    localparam int unsigned DEF_ADDR_W       = 32;
    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned DEF_RESP_TIMEOUT = 64;

    // Starvation counter holds 0..15, response timer holds 0..255.
    localparam int unsigned STARVE_W = 4;
    localparam int unsigned TIMER_W  = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        DRAIN     = 2'd2
    } arb_state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/dsp_arb_starve_ctr.sv
// Saturating starvation counter for the memory-port arbiter.
// Counts data grants issued while fetch was waiting; once the count reaches
// STARVE_LIMIT the data requester may no longer beat a pending fetch.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   if_req        fetch request pending
//   d_grant       data request granted this cycle
//   if_grant      fetch request granted this cycle
//   data_may_win  count below STARVE_LIMIT, data keeps priority
module dsp_arb_starve_ctr
    import dsp_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic d_grant,
    input  logic if_grant,
    output logic data_may_win
);

    logic [STARVE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (if_grant) begin
            cnt_d = '0;
        end else if (d_grant && if_req && (cnt_q != '1)) begin
            cnt_d = cnt_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign data_may_win = (cnt_q < STARVE_W'(STARVE_LIMIT));

endmodule

// File: rtl/dsp_mem_port_arbiter.sv
// Arbiter sharing the core's single memory port between instruction fetch (if_*)
// and the load/store path (d_*). One transaction outstanding at a time; data has
// priority unless fetch has been starved STARVE_LIMIT times in a row. Responses are
// routed combinationally to the owner; a missing response after RESP_TIMEOUT cycles
// produces an error response, and the late memory response is later discarded.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   if_req/if_addr        fetch request;  if_gnt, if_rvalid/if_rdata/if_err  fetch side
//   d_req/d_we/d_be/...   data request;   d_gnt,  d_rvalid/d_rdata/d_err     data side
//   m_req/m_we/m_be/...   memory request; m_gnt, m_rvalid/m_rdata            memory side
//   busy                  transaction outstanding (state != IDLE)
// Optional macro DSP_MEM_ARB_PERF_EN adds saturating perf_conflict_cnt (IDLE cycles
// with both requesters active) and perf_timeout_cnt (synthesised error responses).
module dsp_mem_port_arbiter
    import dsp_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int unsigned RESP_TIMEOUT = DEF_RESP_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
`ifdef DSP_MEM_ARB_PERF_EN
    output logic [31:0]         perf_conflict_cnt,
    output logic [15:0]         perf_timeout_cnt,
`endif
    output logic                busy
);

    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(RESP_TIMEOUT - 1);

    arb_state_e         state_q, state_d;
    logic               owner_q, owner_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic              data_may_win;
    logic              win_d, win_if;
    logic              resp_valid, resp_err;
    logic [DATA_W-1:0] resp_data;

    dsp_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req       (if_req),
        .d_grant      (d_gnt),
        .if_grant     (if_gnt),
        .data_may_win (data_may_win)
    );

    // Data wins unless fetch is waiting and has already been starved too long.
    assign win_d  = d_req && (!if_req || data_may_win);
    assign win_if = if_req && !win_d;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        timer_d    = timer_q;
        m_req      = 1'b0;
        m_we       = 1'b0;
        m_be       = '0;
        m_addr     = '0;
        m_wdata    = '0;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_data  = '0;

        unique case (state_q)
            IDLE: begin
                if (win_d) begin
                    m_req   = 1'b1;
                    m_we    = d_we;
                    m_be    = d_be;
                    m_addr  = d_addr;
                    m_wdata = d_wdata;
                end else if (win_if) begin
                    m_req  = 1'b1;
                    m_be   = '1;
                    m_addr = if_addr;
                end
                if (m_req && m_gnt) begin
                    d_gnt   = win_d;
                    if_gnt  = win_if;
                    owner_d = win_d ? OWN_D : OWN_IF;
                    timer_d = '0;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                timer_d = timer_q + TIMER_W'(1);
                if (m_rvalid) begin
                    resp_valid = 1'b1;
                    resp_data  = m_rdata;
                    state_d    = IDLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                // The late response belongs to an already-errored transaction.
                if (m_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
        end
    end

    assign if_rvalid = resp_valid && (owner_q == OWN_IF);
    assign if_err    = resp_err && (owner_q == OWN_IF);
    assign if_rdata  = (owner_q == OWN_IF) ? resp_data : '0;
    assign d_rvalid  = resp_valid && (owner_q == OWN_D);
    assign d_err     = resp_err && (owner_q == OWN_D);
    assign d_rdata   = (owner_q == OWN_D) ? resp_data : '0;
    assign busy      = (state_q != IDLE);

`ifdef DSP_MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_conflict_cnt <= '0;
            perf_timeout_cnt  <= '0;
        end else begin
            if ((state_q == IDLE) && if_req && d_req && (perf_conflict_cnt != '1)) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
            if (resp_valid && resp_err && (perf_timeout_cnt != '1)) begin
                perf_timeout_cnt <= perf_timeout_cnt + 16'd1;
            end
        end
    end
`else
    // Performance counters are not built.
`endif

endmodule

// File: tb/tb_dsp_mem_port_arbiter.sv
// Self-checking bench for dsp_mem_port_arbiter: directed scenarios with literal
// expectations followed by randomized traffic, all outputs compared every cycle
// against a transaction-level model of the arbiter.
module tb_dsp_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned SL = 4;
    localparam int unsigned RT = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid, if_err;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [BW-1:0] d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid, d_err;
    logic [DW-1:0] d_rdata;
    logic          m_req, m_we;
    logic [BW-1:0] m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_gnt, m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          busy;
`ifdef DSP_MEM_ARB_PERF_EN
    logic [31:0]   perf_conflict_cnt;
    logic [15:0]   perf_timeout_cnt;
`endif

    dsp_mem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (SL),
        .RESP_TIMEOUT (RT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_be      (m_be),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_gnt     (m_gnt),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
`ifdef DSP_MEM_ARB_PERF_EN
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_timeout_cnt  (perf_timeout_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: is a transaction open, who owns it, how many cycles
    // since it was granted, and whether its error was already reported.
    bit          busy_m, drain_m, own_d;
    int          since_gnt, starve;
    int unsigned conf_m, tmo_m;

    logic          e_if_gnt, e_if_rvalid, e_if_err, e_d_gnt, e_d_rvalid, e_d_err;
    logic [DW-1:0] e_if_rdata, e_d_rdata, e_m_wdata;
    logic          e_m_req, e_m_we, e_busy, e_data_wins;
    logic [BW-1:0] e_m_be;
    logic [AW-1:0] e_m_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0;
        d_wdata = '0; m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    // Wait for the falling edge, predict every output, compare.
    task automatic settle();
        logic          v, er;
        logic [DW-1:0] dat;
        @(negedge clk);
        {e_if_gnt, e_if_rvalid, e_if_err, e_d_gnt, e_d_rvalid, e_d_err} = '0;
        {e_m_req, e_m_we, e_busy, e_data_wins} = '0;
        e_if_rdata = '0; e_d_rdata = '0; e_m_wdata = '0; e_m_be = '0; e_m_addr = '0;
        v = 0; er = 0; dat = '0;
        if (rst_n) begin
            if (!busy_m) begin
                if (d_req && (!if_req || starve < int'(SL))) begin
                    e_data_wins = 1; e_m_req = 1; e_m_we = d_we; e_m_be = d_be;
                    e_m_addr = d_addr; e_m_wdata = d_wdata; e_d_gnt = m_gnt;
                end else if (if_req) begin
                    e_m_req = 1; e_m_be = '1; e_m_addr = if_addr; e_if_gnt = m_gnt;
                end
            end else begin
                e_busy = 1;
                if (!drain_m) begin
                    if (m_rvalid) begin
                        v = 1; dat = m_rdata;
                    end else if (since_gnt == int'(RT)) begin
                        v = 1; er = 1;
                    end
                    if (own_d) begin
                        e_d_rvalid = v; e_d_err = er; e_d_rdata = dat;
                    end else begin
                        e_if_rvalid = v; e_if_err = er; e_if_rdata = dat;
                    end
                end
            end
        end
        chk("if_gnt", if_gnt, e_if_gnt);
        chk("d_gnt", d_gnt, e_d_gnt);
        chk("if_rvalid", if_rvalid, e_if_rvalid);
        chk("if_err", if_err, e_if_err);
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rvalid", d_rvalid, e_d_rvalid);
        chk("d_err", d_err, e_d_err);
        chk("d_rdata", d_rdata, e_d_rdata);
        chk("m_req", m_req, e_m_req);
        chk("busy", busy, e_busy);
        if (e_m_req) begin
            chk("m_we", m_we, e_m_we);
            chk("m_be", m_be, e_m_be);
            chk("m_addr", m_addr, e_m_addr);
            if (e_data_wins) chk("m_wdata", m_wdata, e_m_wdata);
        end
`ifdef DSP_MEM_ARB_PERF_EN
        chk("perf_conflict_cnt", perf_conflict_cnt, conf_m);
        chk("perf_timeout_cnt", perf_timeout_cnt, tmo_m);
`endif
    endtask

    // Apply what the coming rising edge does to the model, then step past it.
    task automatic advance();
        if (!rst_n) begin
            busy_m = 0; drain_m = 0; starve = 0; since_gnt = 0; conf_m = 0; tmo_m = 0;
        end else if (!busy_m) begin
            if (if_req && d_req && conf_m != 32'hffff_ffff) conf_m++;
            if (e_d_gnt) begin
                busy_m = 1; own_d = 1; since_gnt = 1;
                if (if_req && starve < 15) starve++;
            end else if (e_if_gnt) begin
                busy_m = 1; own_d = 0; since_gnt = 1; starve = 0;
            end
        end else if (!drain_m) begin
            if (m_rvalid) busy_m = 0;
            else if (since_gnt == int'(RT)) begin
                drain_m = 1;
                if (tmo_m != 16'hffff) tmo_m++;
            end else since_gnt++;
        end else if (m_rvalid) begin
            busy_m = 0; drain_m = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    bit if_pend, d_pend;
    int resp_cd;

    initial begin
        rst_n = 0;
        clear_inputs();
        busy_m = 0; drain_m = 0; own_d = 0; since_gnt = 0; starve = 0; conf_m = 0; tmo_m = 0;
        repeat (2) @(posedge clk);
        #1;
        settle();
        chk("reset_busy", busy, 0);
        chk("reset_m_req", m_req, 0);
        advance();
        rst_n = 1;
        tick();

        // Fetch only, response 3 cycles after grant.
        if_req = 1; if_addr = 32'h1000; m_gnt = 1;
        settle();
        chk("t1_if_gnt", if_gnt, 1);
        chk("t1_m_addr", m_addr, 32'h1000);
        chk("t1_m_be", m_be, 4'hf);
        advance();
        clear_inputs();
        tick(); tick();
        m_rvalid = 1; m_rdata = 32'h0000_0013;
        settle();
        chk("t1_if_rvalid", if_rvalid, 1);
        chk("t1_if_rdata", if_rdata, 32'h13);
        chk("t1_d_rvalid", d_rvalid, 0);
        advance();
        clear_inputs();
        tick();

        // Both requesting: four data grants, then fetch forced through.
        if_req = 1; if_addr = 32'h4000; d_req = 1; d_be = 4'hf;
        for (int i = 0; i < 5; i++) begin
            d_addr = 32'h5000 + 32'(i * 4); m_gnt = 1; m_rvalid = 0;
            settle();
            chk("t2_d_gnt", d_gnt, (i < 4));
            chk("t2_if_gnt", if_gnt, (i == 4));
            advance();
            m_gnt = 0; m_rvalid = 1; m_rdata = $urandom;
            if (i == 4) if_req = 0;
            tick();
            m_rvalid = 0;
        end
        if_req = 1; m_gnt = 1;
        settle();
        chk("t2_d_wins_after_clear", d_gnt, 1);
        advance();
        clear_inputs(); m_rvalid = 1;
        tick();
        clear_inputs();

        // Store with partial byte enables.
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
        m_gnt = 1;
        settle();
        chk("t3_d_gnt", d_gnt, 1);
        chk("t3_m_we", m_we, 1);
        chk("t3_m_be", m_be, 4'b0011);
        chk("t3_m_wdata", m_wdata, 32'hDEAD_BEEF);
        advance();
        clear_inputs(); m_rvalid = 1; m_rdata = 32'h1234_5678;
        settle();
        chk("t3_d_rvalid", d_rvalid, 1);
        chk("t3_d_err", d_err, 0);
        advance();
        clear_inputs();

        // Load that times out, late response dropped, then a normal fetch.
        d_req = 1; d_addr = 32'h7000; d_be = 4'hf; m_gnt = 1;
        settle();
        chk("t4_d_gnt", d_gnt, 1);
        advance();
        clear_inputs();
        repeat (RT - 1) tick();
        settle();
        chk("t4_d_rvalid", d_rvalid, 1);
        chk("t4_d_err", d_err, 1);
        chk("t4_d_rdata", d_rdata, 0);
        advance();
        tick();
        m_rvalid = 1; m_rdata = 32'hAAAA_5555;
        settle();
        chk("t4_late_dropped", d_rvalid, 0);
        chk("t4_drain_busy", busy, 1);
        advance();
        clear_inputs();
        if_req = 1; if_addr = 32'h1100; m_gnt = 1;
        settle();
        chk("t4_if_gnt", if_gnt, 1);
        advance();
        clear_inputs(); m_rvalid = 1; m_rdata = 32'h0000_0067;
        settle();
        chk("t4_if_rvalid", if_rvalid, 1);
        chk("t4_if_err", if_err, 0);
        chk("t4_if_rdata", if_rdata, 32'h67);
        advance();
        clear_inputs();

        // Memory stalls the grant for 5 cycles.
        if_req = 1; if_addr = 32'h3000; m_gnt = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t5_m_req_held", m_req, 1);
            chk("t5_m_addr_stable", m_addr, 32'h3000);
            chk("t5_no_gnt", if_gnt, 0);
            advance();
        end
        m_gnt = 1;
        settle();
        chk("t5_if_gnt", if_gnt, 1);
        advance();
        clear_inputs(); m_rvalid = 1;
        tick();
        clear_inputs();

        // Reset during WAIT_RESP, stray response after release.
        if_req = 1; if_addr = 32'h6000; m_gnt = 1;
        tick();
        clear_inputs();
        tick();
        rst_n = 0; m_rvalid = 1; m_rdata = 32'hFFFF_FFFF;
        settle();
        chk("t6_busy_in_reset", busy, 0);
        chk("t6_if_rvalid_in_reset", if_rvalid, 0);
        chk("t6_if_rdata_in_reset", if_rdata, 0);
        advance();
        rst_n = 1; m_rvalid = 1;
        settle();
        chk("t6_stray_if_rvalid", if_rvalid, 0);
        chk("t6_stray_d_rvalid", d_rvalid, 0);
`ifdef DSP_MEM_ARB_PERF_EN
        chk("t6_perf_conflict_zero", perf_conflict_cnt, 0);
        chk("t6_perf_timeout_zero", perf_timeout_cnt, 0);
`endif
        advance();
        clear_inputs();
        tick();

        // Randomized traffic; memory answers 1..11 cycles after grant.
        if_pend = 0; d_pend = 0; resp_cd = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_we = 1'($urandom); d_be = 4'($urandom);
                d_addr = $urandom; d_wdata = $urandom;
            end
            if_req = if_pend; d_req = d_pend;
            m_gnt = ($urandom_range(0, 3) != 0);
            m_rdata = $urandom;
            m_rvalid = 0;
            if (resp_cd > 0) begin
                resp_cd--;
                if (resp_cd == 0) m_rvalid = 1;
            end
            settle();
            if (e_if_gnt) if_pend = 0;
            if (e_d_gnt) d_pend = 0;
            if (e_if_gnt || e_d_gnt) resp_cd = $urandom_range(1, 11);
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
